// File: rtl/counter_10.sv
// Free-running modulo-MODULUS counter with a wrap flag for cascading digits.
// o_wrap is decoded straight from the count register, so it is clean relative to clk.
`timescale 1ns/100ps
module counter_10 #(
    parameter int MODULUS = 10,
    parameter int WIDTH   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    generate
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $error("counter_10: MODULUS must lie in 2..2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // >= rather than == so an upset into an unused code drops back to 0.
    always_comb begin
        cnt_d = cnt_q + WIDTH'(1);
        if (cnt_q >= LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt  = cnt_q;
    assign o_wrap = (cnt_q == LAST);

endmodule

// File: tb/tb_counter_10.sv
// Bench for counter_10: a decade build and a modulo-6 build share clk and rst_n;
// both are compared every falling edge against an edge-count model.
`timescale 1ns/100ps
module tb_counter_10;

    logic       clk;
    logic       rst_n;
    logic [3:0] cnt10;
    logic       wrap10;
    logic [2:0] cnt6;
    logic       wrap6;

    int tests;
    int fails;
    int edges10;
    int edges6;
    bit check_en;

    counter_10 #(.MODULUS(10), .WIDTH(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_cnt  (cnt10),
        .o_wrap (wrap10)
    );

    counter_10 #(.MODULUS(6), .WIDTH(3)) dut6 (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_cnt  (cnt6),
        .o_wrap (wrap6)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the count is simply the number of clocked edges since reset, mod MODULUS.
    always @(posedge clk) begin
        if (rst_n) begin
            edges10++;
            edges6++;
        end
    end

    always @(negedge clk) begin
        #0.2;
        if (check_en) begin
            check("model_cnt10", int'(cnt10), edges10 % 10);
            check("model_wrap10", int'(wrap10), int'(edges10 % 10 == 9));
            check("model_cnt6", int'(cnt6), edges6 % 6);
            check("model_wrap6", int'(wrap6), int'(edges6 % 6 == 5));
        end
    end

    // Reset is asserted between edges, checked before the next edge, then released
    // mid-cycle after some edges of hold.
    task automatic reset_pulse(input int hold_edges);
        @(posedge clk);
        #0.5;
        rst_n   = 1'b0;
        edges10 = 0;
        edges6  = 0;
        #0.2;
        check("async_rst_cnt", int'(cnt10), 0);
        check("async_rst_wrap", int'(wrap10), 0);
        check("async_rst_cnt6", int'(cnt6), 0);
        repeat (hold_edges) @(posedge clk);
        @(negedge clk);
        #0.5;
        rst_n = 1'b1;
    endtask

    task automatic run_to10(input int target);
        for (int i = 0; i < 10; i++) begin
            if (edges10 % 10 == target) break;
            @(negedge clk);
            #0.3;
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        edges10  = 0;
        edges6   = 0;
        check_en = 1'b1;
        rst_n    = 1'b0;

        repeat (3) begin
            @(negedge clk);
            #0.3;
            check("hold_rst_cnt", int'(cnt10), 0);
            check("hold_rst_wrap", int'(wrap10), 0);
        end

        #0.5;
        rst_n = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            #0.3;
            if (k == 1) check("first_edge", int'(cnt10), 1);
            if (k == 5) begin
                check("m6_at5", int'(cnt6), 5);
                check("m6_wrap_at5", int'(wrap6), 1);
            end
            if (k == 6) begin
                check("m6_at6", int'(cnt6), 0);
                check("m6_wrap_at6", int'(wrap6), 0);
            end
            if (k == 8) check("wrap_before9", int'(wrap10), 0);
            if (k == 9) begin
                check("cnt_at9", int'(cnt10), 9);
                check("wrap_at9", int'(wrap10), 1);
            end
            if (k == 10) begin
                check("cnt_at10", int'(cnt10), 0);
                check("wrap_at10", int'(wrap10), 0);
            end
        end
        check("cnt_after22", int'(cnt10), 2);

        run_to10(6);
        check("mid_value6", int'(cnt10), 6);
        reset_pulse(2);
        @(negedge clk);
        #0.3;
        check("restart_one", int'(cnt10), 1);

        // Deposit an illegal code while the register sits at 9.
        run_to10(9);
        check_en = 1'b0;
        force dut.cnt_q = 4'd12;
        #0.1;
        check("illegal_wrap", int'(wrap10), 0);
        release dut.cnt_q;
        @(negedge clk);
        #0.3;
        check("illegal_recover", int'(cnt10), 0);
        edges10  = 0;
        check_en = 1'b1;

        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(35, 1)) @(negedge clk);
            reset_pulse(int'($urandom_range(3, 1)));
        end
        repeat (25) @(negedge clk);

        #0.5;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

endmodule
